// File: rtl/hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_fwd_ctrl
//
// Hazard and forwarding controller for the decode/execute boundary. It keeps
// its own copy of the execute-stage instruction plus a shift register of
// DEPTH producer tags for the stages downstream of execute. From that state it
// derives operand forwarding selects, load-use stalls and branch flushes.
//
// Parameters
//   DEPTH    : producer stages tracked beyond E (index 1 = just after E,
//              index DEPTH = oldest). Must be at least LOAD_LAT+1.
//   LOAD_LAT : extra cycles before a load result can be forwarded.
//   CNT_W    : width of the saturating stall counter.
//   SELW     : forwarding select width, $clog2(DEPTH+1) (not overridable).
//
// Ports
//   clk        in          clock
//   rst        in          asynchronous active-high reset
//   inst_d     in  [31:0]  instruction in decode
//   valid_d    in          inst_d is real; otherwise treated as NOP
//   br_taken_e in          branch/jump in E resolved taken this cycle
//   inst_e     out [31:0]  instruction held in E
//   fwd_a      out [SELW]  rs1 source: 0 = register file, k = stage k
//   fwd_b      out [SELW]  rs2 source, same encoding
//   stall_d    out         hold PC and IF/ID, bubble into E
//   flush_d    out         discard decode instruction, bubble into E
//   stall_cnt  out [CNT_W] saturating count of stall cycles
// ---------------------------------------------------------------------------
module hazard_fwd_ctrl #(
    parameter int DEPTH    = 2,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32,
    localparam int SELW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_d,
    input  logic             valid_d,
    input  logic             br_taken_e,
    output logic [31:0]      inst_e,
    output logic [SELW-1:0]  fwd_a,
    output logic [SELW-1:0]  fwd_b,
    output logic             stall_d,
    output logic             flush_d,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [31:0] NOP_INST  = 32'h0000_0013;

    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_OP     = 7'b0110011;
    localparam logic [6:0]  OP_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    function automatic logic writesRd(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_OP, OP_OPIMM, OP_LOAD};
    endfunction

    function automatic logic usesRs1(input logic [6:0] op);
        return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
    endfunction

    function automatic logic usesRs2(input logic [6:0] op);
        return op inside {OP_OP, OP_STORE, OP_BRANCH};
    endfunction

    // Registered state: execute instruction, producer tags, stall counter
    logic [31:0]      instE_q, instE_d;
    logic [DEPTH:1]   tagWr_q, tagWr_d;
    logic [DEPTH:1]   tagLoad_q, tagLoad_d;
    logic [4:0]       tagRd_q [DEPTH:1];
    logic [4:0]       tagRd_d [DEPTH:1];
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

    // Field extraction for the E and D instructions
    logic [6:0] opE, opD;
    logic [4:0] rdE, rs1E, rs2E, rs1D, rs2D;

    assign opE  = instE_q[6:0];
    assign rdE  = instE_q[11:7];
    assign rs1E = instE_q[19:15];
    assign rs2E = instE_q[24:20];
    assign opD  = inst_d[6:0];
    assign rs1D = inst_d[19:15];
    assign rs2D = inst_d[24:20];

    // Bits of the instruction words that no hazard decision depends on
    logic unusedBits;
    assign unusedBits = ^{inst_d[31:25], inst_d[14:7], instE_q[31:25], instE_q[14:12]};

    // A tag can feed the operand muxes only if it writes a real register and,
    // for loads, the data has had LOAD_LAT extra cycles to come back.
    logic [DEPTH:1] tagFwdOk;

    always_comb begin
        tagFwdOk = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            tagFwdOk[k] = tagWr_q[k] && (tagRd_q[k] != 5'd0) && (!tagLoad_q[k] || (k > LOAD_LAT));
        end
    end

    // Forwarding selects: scan oldest to youngest so the youngest match is
    // the one left standing.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (usesRs1(opE) && tagFwdOk[k] && (tagRd_q[k] == rs1E)) begin
                fwd_a = SELW'(k);
            end
            if (usesRs2(opE) && tagFwdOk[k] && (tagRd_q[k] == rs2E)) begin
                fwd_b = SELW'(k);
            end
        end
    end

    // Load-use detection on the decode instruction. A load at distance d
    // (E = 0, tag k = k) is still in flight while d+1 <= LOAD_LAT. A source
    // of x0 never matches, which also keeps loads into x0 from stalling.
    logic srcAValid, srcBValid, hitA, hitB, loadUse;

    always_comb begin
        srcAValid = usesRs1(opD) && (rs1D != 5'd0);
        srcBValid = usesRs2(opD) && (rs2D != 5'd0);
        hitA      = 1'b0;
        hitB      = 1'b0;
        if ((LOAD_LAT >= 1) && (opE == OP_LOAD)) begin
            hitA = (rdE == rs1D);
            hitB = (rdE == rs2D);
        end
        for (int k = 1; k <= DEPTH; k++) begin
            if ((k + 1 <= LOAD_LAT) && tagWr_q[k] && tagLoad_q[k]) begin
                if (tagRd_q[k] == rs1D) hitA = 1'b1;
                if (tagRd_q[k] == rs2D) hitB = 1'b1;
            end
        end
        loadUse = valid_d && ((srcAValid && hitA) || (srcBValid && hitB));
    end

    // A taken branch discards the decode instruction anyway, so it suppresses
    // any stall and the two collapse into one bubble.
    assign flush_d = br_taken_e;
    assign stall_d = loadUse && !br_taken_e;

    // Next-state: tags always advance; E takes a bubble on stall/flush
    always_comb begin
        tagWr_d      = '0;
        tagLoad_d    = '0;
        tagWr_d[1]   = writesRd(opE);
        tagRd_d[1]   = rdE;
        tagLoad_d[1] = (opE == OP_LOAD);
        for (int k = 2; k <= DEPTH; k++) begin
            tagWr_d[k]   = tagWr_q[k-1];
            tagRd_d[k]   = tagRd_q[k-1];
            tagLoad_d[k] = tagLoad_q[k-1];
        end

        if (flush_d || stall_d) begin
            instE_d = NOP_INST;
        end else if (valid_d) begin
            instE_d = inst_d;
        end else begin
            instE_d = NOP_INST;
        end

        stallCnt_d = stallCnt_q;
        if (stall_d && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instE_q    <= NOP_INST;
            tagWr_q    <= '0;
            tagLoad_q  <= '0;
            stallCnt_q <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                tagRd_q[k] <= 5'd0;
            end
        end else begin
            instE_q    <= instE_d;
            tagWr_q    <= tagWr_d;
            tagLoad_q  <= tagLoad_d;
            stallCnt_q <= stallCnt_d;
            for (int k = 1; k <= DEPTH; k++) begin
                tagRd_q[k] <= tagRd_d[k];
            end
        end
    end

    assign inst_e    = instE_q;
    assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//
// Drives two controller instances: dut1 with default parameters
// (DEPTH=2, LOAD_LAT=1) and dut2 with DEPTH=3, LOAD_LAT=2. Each step drives
// one instance's decode inputs, pushes the hand-derived expected outputs for
// that cycle into a scoreboard queue, and pops/compares them at the falling
// edge.
// ---------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;

    logic [31:0] instD1, instD2;
    logic        validD1, validD2, brE1, brE2;
    logic [31:0] instE1, instE2;
    logic [1:0]  fwdA1, fwdB1, fwdA2, fwdB2;
    logic        stall1, stall2, flush1, flush2;
    logic [31:0] cnt1, cnt2;

    hazard_fwd_ctrl dut1 (
        .clk        (clk),
        .rst        (rst),
        .inst_d     (instD1),
        .valid_d    (validD1),
        .br_taken_e (brE1),
        .inst_e     (instE1),
        .fwd_a      (fwdA1),
        .fwd_b      (fwdB1),
        .stall_d    (stall1),
        .flush_d    (flush1),
        .stall_cnt  (cnt1)
    );

    hazard_fwd_ctrl #(.DEPTH(3), .LOAD_LAT(2), .CNT_W(32)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .inst_d     (instD2),
        .valid_d    (validD2),
        .br_taken_e (brE2),
        .inst_e     (instE2),
        .fwd_a      (fwdA2),
        .fwd_b      (fwdB2),
        .stall_d    (stall2),
        .flush_d    (flush2),
        .stall_cnt  (cnt2)
    );

    // Free-running clock, 10 time-unit period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          sel;
        int          step;
        logic [31:0] instE;
        int          fwdA;
        int          fwdB;
        int          stall;
        int          flush;
        int          cnt;
    } expT;

    expT scoreboard[$];
    int  checks  = 0;
    int  errors  = 0;
    int  stepNo  = 0;

    // Instruction encoders
    function automatic logic [31:0] encR(input int rd, input int rs1, input int rs2, input bit isSub);
        logic [4:0] d, s1, s2;
        d  = rd[4:0];
        s1 = rs1[4:0];
        s2 = rs2[4:0];
        return {(isSub ? 7'h20 : 7'h00), s2, s1, 3'b000, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] encI(input logic [6:0] op, input logic [2:0] f3, input int rd, input int rs1, input int imm);
        logic [4:0]  d, s1;
        logic [11:0] im;
        d  = rd[4:0];
        s1 = rs1[4:0];
        im = imm[11:0];
        return {im, s1, f3, d, op};
    endfunction

    function automatic logic [31:0] encSw(input int rs2, input int rs1, input int imm);
        logic [4:0]  s1, s2;
        logic [11:0] im;
        s1 = rs1[4:0];
        s2 = rs2[4:0];
        im = imm[11:0];
        return {im[11:5], s2, s1, 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return encI(7'b0010011, 3'b000, rd, rs1, imm);
    endfunction

    function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
        return encI(7'b0000011, 3'b010, rd, rs1, imm);
    endfunction

    // The single comparison point
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Pop the oldest expectation and compare it against the selected DUT
    task automatic compareFront();
        expT         e;
        logic [31:0] aInst, aFwdA, aFwdB, aStall, aFlush, aCnt;
        string       pfx;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty actual=0 expected=1");
            return;
        end
        e = scoreboard.pop_front();
        if (e.sel == 1) begin
            aInst = instE1;  aFwdA = 32'(fwdA1); aFwdB = 32'(fwdB1);
            aStall = 32'(stall1); aFlush = 32'(flush1); aCnt = cnt1;
        end else begin
            aInst = instE2;  aFwdA = 32'(fwdA2); aFwdB = 32'(fwdB2);
            aStall = 32'(stall2); aFlush = 32'(flush2); aCnt = cnt2;
        end
        pfx = $sformatf("s%0d.dut%0d", e.step, e.sel);
        checkOutput({pfx, ".inst_e"},    aInst,  e.instE);
        checkOutput({pfx, ".fwd_a"},     aFwdA,  32'(e.fwdA));
        checkOutput({pfx, ".fwd_b"},     aFwdB,  32'(e.fwdB));
        checkOutput({pfx, ".stall_d"},   aStall, 32'(e.stall));
        checkOutput({pfx, ".flush_d"},   aFlush, 32'(e.flush));
        checkOutput({pfx, ".stall_cnt"}, aCnt,   32'(e.cnt));
    endtask

    task automatic pushExp(input int sel, input logic [31:0] eInst, input int eFwdA, input int eFwdB,
                           input int eStall, input int eFlush, input int eCnt);
        expT e;
        e.sel   = sel;
        e.step  = stepNo;
        e.instE = eInst;
        e.fwdA  = eFwdA;
        e.fwdB  = eFwdB;
        e.stall = eStall;
        e.flush = eFlush;
        e.cnt   = eCnt;
        scoreboard.push_back(e);
    endtask

    // One cycle: drive decode inputs of one instance (the other idles with
    // invalid NOPs), queue the expected outputs, compare at the falling edge.
    task automatic applyStimulus(input int sel, input logic [31:0] inst, input bit valid, input bit br,
                                 input logic [31:0] eInst, input int eFwdA, input int eFwdB,
                                 input int eStall, input int eFlush, input int eCnt);
        @(posedge clk);
        #1;
        stepNo++;
        if (sel == 1) begin
            instD1 = inst; validD1 = valid; brE1 = br;
            instD2 = NOP;  validD2 = 1'b0;  brE2 = 1'b0;
        end else begin
            instD2 = inst; validD2 = valid; brE2 = br;
            instD1 = NOP;  validD1 = 1'b0;  brE1 = 1'b0;
        end
        pushExp(sel, eInst, eFwdA, eFwdB, eStall, eFlush, eCnt);
        @(negedge clk);
        compareFront();
    endtask

    // Asynchronous reset check: both instances must be back at reset values
    // before any clock edge occurs.
    task automatic checkResetNow();
        stepNo++;
        pushExp(1, NOP, 0, 0, 0, 0, 0);
        pushExp(2, NOP, 0, 0, 0, 0, 0);
        #1;
        compareFront();
        compareFront();
    endtask

    initial begin
        rst     = 1'b1;
        instD1  = NOP; validD1 = 1'b0; brE1 = 1'b0;
        instD2  = NOP; validD2 = 1'b0; brE2 = 1'b0;
        #1;
        checkResetNow();
        #1;
        rst = 1'b0;

        // ---------------- dut1: DEPTH=2, LOAD_LAT=1 ----------------
        // ALU chain, back to back: forward from stage 1
        applyStimulus(1, encR(5, 1, 2, 0), 1, 0, NOP,               0, 0, 0, 0, 0);
        applyStimulus(1, encR(6, 5, 5, 1), 1, 0, encR(5, 1, 2, 0),  0, 0, 0, 0, 0);
        applyStimulus(1, NOP,              0, 0, encR(6, 5, 5, 1),  1, 1, 0, 0, 0);
        // ALU chain with one NOP between: forward from stage 2
        applyStimulus(1, encR(5, 1, 2, 0), 1, 0, NOP,               0, 0, 0, 0, 0);
        applyStimulus(1, NOP,              1, 0, encR(5, 1, 2, 0),  0, 0, 0, 0, 0);
        applyStimulus(1, encR(6, 5, 5, 1), 1, 0, NOP,               0, 0, 0, 0, 0);
        applyStimulus(1, NOP,              0, 0, encR(6, 5, 5, 1),  2, 2, 0, 0, 0);
        // Load-use: one stall cycle, one bubble, then forward from stage 2
        applyStimulus(1, lw(7, 1, 0),      1, 0, NOP,               0, 0, 0, 0, 0);
        applyStimulus(1, encR(8, 7, 3, 0), 1, 0, lw(7, 1, 0),       0, 0, 1, 0, 0);
        applyStimulus(1, encR(8, 7, 3, 0), 1, 0, NOP,               0, 0, 0, 0, 1);
        applyStimulus(1, NOP,              0, 0, encR(8, 7, 3, 0),  2, 0, 0, 0, 1);
        // x0 is never forwarded
        applyStimulus(1, addi(0, 0, 5),    1, 0, NOP,               0, 0, 0, 0, 1);
        applyStimulus(1, encR(9, 0, 0, 0), 1, 0, addi(0, 0, 5),     0, 0, 0, 0, 1);
        // Two producers of x4: youngest wins
        applyStimulus(1, addi(4, 1, 1),    1, 0, encR(9, 0, 0, 0),  0, 0, 0, 0, 1);
        applyStimulus(1, addi(4, 4, 2),    1, 0, addi(4, 1, 1),     0, 0, 0, 0, 1);
        applyStimulus(1, encR(10, 4, 4, 0),1, 0, addi(4, 4, 2),     1, 0, 0, 0, 1);
        applyStimulus(1, NOP,              0, 0, encR(10, 4, 4, 0), 1, 1, 0, 0, 1);
        // Load into x0 never stalls
        applyStimulus(1, lw(0, 1, 0),      1, 0, NOP,               0, 0, 0, 0, 1);
        applyStimulus(1, encR(11, 0, 0, 0),1, 0, lw(0, 1, 0),       0, 0, 0, 0, 1);
        // Flush overrides a load-use stall: one bubble, counter unchanged
        applyStimulus(1, lw(12, 1, 0),     1, 0, encR(11, 0, 0, 0), 0, 0, 0, 0, 1);
        applyStimulus(1, encR(13,12,12,0), 1, 1, lw(12, 1, 0),      0, 0, 0, 1, 1);
        applyStimulus(1, NOP,              0, 0, NOP,               0, 0, 0, 0, 1);
        // Store creates no tag even though its imm[4:0] looks like rd=x8
        applyStimulus(1, encSw(2, 1, 8),   1, 0, NOP,               0, 0, 0, 0, 1);
        applyStimulus(1, encR(9, 8, 8, 0), 1, 0, encSw(2, 1, 8),    0, 0, 0, 0, 1);
        applyStimulus(1, NOP,              0, 0, encR(9, 8, 8, 0),  0, 0, 0, 0, 1);

        // ---------------- dut2: DEPTH=3, LOAD_LAT=2 ----------------
        // Load-use: two stall cycles, then forward from stage 3
        applyStimulus(2, lw(7, 1, 0),      1, 0, NOP,               0, 0, 0, 0, 0);
        applyStimulus(2, encR(8, 7, 3, 0), 1, 0, lw(7, 1, 0),       0, 0, 1, 0, 0);
        applyStimulus(2, encR(8, 7, 3, 0), 1, 0, NOP,               0, 0, 1, 0, 1);
        applyStimulus(2, encR(8, 7, 3, 0), 1, 0, NOP,               0, 0, 0, 0, 2);
        applyStimulus(2, NOP,              0, 0, encR(8, 7, 3, 0),  3, 0, 0, 0, 2);
        // Dependent load chain: LOAD_LAT stalls per link
        applyStimulus(2, lw(20, 1, 0),     1, 0, NOP,               0, 0, 0, 0, 2);
        applyStimulus(2, lw(21, 20, 0),    1, 0, lw(20, 1, 0),      0, 0, 1, 0, 2);
        applyStimulus(2, lw(21, 20, 0),    1, 0, NOP,               0, 0, 1, 0, 3);
        applyStimulus(2, lw(21, 20, 0),    1, 0, NOP,               0, 0, 0, 0, 4);
        applyStimulus(2, encR(22,21,0,0),  1, 0, lw(21, 20, 0),     3, 0, 1, 0, 4);
        applyStimulus(2, encR(22,21,0,0),  1, 0, NOP,               0, 0, 1, 0, 5);

        // Reset in the middle of the stall clears it at once
        rst = 1'b1;
        checkResetNow();
        #2;
        rst = 1'b0;
        // The held add entered E on the first edge after reset, unstalled
        applyStimulus(2, NOP,              0, 0, encR(22,21,0,0),   0, 0, 0, 0, 0);

        if (scoreboard.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_leftover actual=%0d expected=0", scoreboard.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
